accum_ctrl: RTL

- Controller and sequencer for the tensor-core accumulator array.
- Takes a group-size configuration and converts it into the adder-chain and output-mux select vectors.
- Gates upstream input so reconfiguration happens only when the accumulator pipeline is empty.
- Tracks in-flight samples and marks the cycle and lanes on which accumulated results are valid.

---
 rtl/accum_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/accum_ctrl.sv
// accum_ctrl: sequencer for the tensor-core accumulator array; turns a group size into chain/mux selects and tracks result validity.
// Latency: out_valid_o follows an accepted input by BYP_LAT (g=1) or BASE_LAT+STAGE_LAT*(g-2) cycles; selects change the cycle after APPLY.
// Backpressure: a pending cfg request drops in_ready_o; cfg_ready_o only with an empty pipeline. ACC_CTRL_PERF_EN adds perf counters.
module accum_ctrl #(
  parameter int IN_SIZE   = 16,
  parameter int BYP_LAT   = 2,
  parameter int BASE_LAT  = 1,
  parameter int STAGE_LAT = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_valid_i,
  input  logic [4:0]         cfg_group_i,
  output logic               cfg_ready_o,
  output logic               cfg_err_o,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [2:IN_SIZE-1] adder_chain_set_o,
  output logic [1:IN_SIZE-1] out_data_mux_o,
  output logic               out_valid_o,
  output logic [0:IN_SIZE-1] out_lane_mask_o,
`ifdef ACC_CTRL_PERF_EN
  output logic [31:0]        perf_samples_o,
  output logic [31:0]        perf_stall_o,
`endif
  output logic               busy_o
);

  localparam int MAX_LAT   = BASE_LAT + STAGE_LAT * (IN_SIZE - 2);
  localparam int DEPTH_A   = (MAX_LAT > BYP_LAT) ? MAX_LAT : BYP_LAT;
  localparam int TAG_DEPTH = (DEPTH_A > 2) ? DEPTH_A : 2;
  localparam int LIDX_W    = $clog2(TAG_DEPTH);
  localparam int CNT_W     = $clog2(TAG_DEPTH + 1);
  localparam logic [4:0] G_MAX = 5'(IN_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_APPLY} state_e;

  state_e               state_q, state_d;
  logic [4:0]           g_q, g_d;
  logic [4:0]           pend_q, pend_d;
  logic [2:IN_SIZE-1]   chain_q, chain_d;
  logic [1:IN_SIZE-1]   mux_q, mux_d;
  logic [0:IN_SIZE-1]   mask_q, mask_d;
  // Tap 0 of the tag line is the live accept; taps 1.. are registered.
  logic [TAG_DEPTH-2:0] tag_q, tag_d;
  logic [TAG_DEPTH-1:0] tag_all;
  logic                 out_valid_q, out_valid_d;
  logic [CNT_W-1:0]     inflight_q, inflight_d;
  logic [LIDX_W-1:0]    lat_idx;
  logic [4:0]           rem [IN_SIZE];
  logic [4:0]           rem_run;
  logic                 cfg_accept;
  logic                 in_accept;
  logic                 g_legal;

  assign g_legal = (pend_q != 5'd0) && (pend_q <= G_MAX);

  // Control FSM: a cfg request blocks new input, waits for the pipeline to empty, then applies for one cycle.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    g_d         = g_q;
    cfg_ready_o = 1'b0;
    in_ready_o  = 1'b0;
    cfg_err_o   = 1'b0;
    cfg_accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cfg_ready_o = (inflight_q == '0);
        cfg_accept  = cfg_valid_i & cfg_ready_o;
        in_ready_o  = ~cfg_accept;
        if (cfg_accept) begin
          state_d = S_APPLY;
          pend_d  = cfg_group_i;
        end else if (in_valid_i) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        in_ready_o = ~cfg_valid_i;
        if (cfg_valid_i) begin
          state_d = S_DRAIN;
        end else if ((inflight_q == '0) && !in_valid_i) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (inflight_q == '0) begin
          state_d = S_IDLE;
        end
      end
      S_APPLY: begin
        if (g_legal) begin
          g_d = pend_q;
        end else begin
          cfg_err_o = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lane position within its group (i mod g), built as a wrapping count to avoid a divider.
  always_comb begin
    rem_run = 5'd0;
    for (int i = 0; i < IN_SIZE; i++) begin
      rem[i]  = rem_run;
      rem_run = (rem_run == g_d - 5'd1) ? 5'd0 : rem_run + 5'd1;
    end
  end

  // Select vectors and lane mask for the group size that will be in force next cycle.
  always_comb begin
    chain_d = '0;
    mux_d   = '0;
    for (int i = 2; i < IN_SIZE; i++) begin
      chain_d[i] = (g_d >= 5'd2) && (rem[i] >= 5'd2);
    end
    for (int i = 1; i < IN_SIZE; i++) begin
      mux_d[i] = (g_d >= 5'd2) && (rem[i] == g_d - 5'd1);
    end
    mask_d[0] = (g_d == 5'd1);
    for (int i = 1; i < IN_SIZE; i++) begin
      mask_d[i] = (g_d == 5'd1) | mux_d[i];
    end
  end

  // Tag-line tap at which a sample completes for the current group size.
  always_comb begin
    if (g_q == 5'd1) begin
      lat_idx = LIDX_W'(BYP_LAT - 1);
    end else begin
      lat_idx = LIDX_W'(BASE_LAT + STAGE_LAT * (int'(g_q) - 2) - 1);
    end
  end

  // Tag shift and in-flight count; tags past the exit tap are dropped so a later longer latency cannot see them.
  always_comb begin
    in_accept = in_valid_i & in_ready_o;
    tag_all   = {tag_q, in_accept};
    for (int k = 0; k < TAG_DEPTH - 1; k++) begin
      tag_d[k] = tag_all[k] & (LIDX_W'(k) < lat_idx);
    end
    out_valid_d = tag_all[lat_idx];
    inflight_d  = inflight_q;
    if (in_accept && !out_valid_q) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!in_accept && out_valid_q) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  // State and datapath registers; reset discards everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      g_q         <= 5'd1;
      pend_q      <= 5'd1;
      chain_q     <= '0;
      mux_q       <= '0;
      mask_q      <= '1;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      pend_q      <= pend_d;
      chain_q     <= chain_d;
      mux_q       <= mux_d;
      mask_q      <= mask_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      inflight_q  <= inflight_d;
    end
  end

  assign adder_chain_set_o = chain_q;
  assign out_data_mux_o    = mux_q;
  assign out_lane_mask_o   = mask_q;
  assign out_valid_o       = out_valid_q;
  assign busy_o            = (inflight_q != '0) || (state_q != S_IDLE);

`ifdef ACC_CTRL_PERF_EN
  logic [31:0] perf_samples_q, perf_samples_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Saturating counters of delivered results and stalled input cycles.
  always_comb begin
    perf_samples_d = perf_samples_q;
    perf_stall_d   = perf_stall_q;
    if (out_valid_q && (perf_samples_q != '1)) begin
      perf_samples_d = perf_samples_q + 32'd1;
    end
    if (in_valid_i && !in_ready_o && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_samples_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_samples_q <= perf_samples_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_samples_o = perf_samples_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule
